// File: rtl/fifo_rd_burst_arb.sv
// Read-side burst scheduler for the async FIFO: round-robin grants whole bursts
// to NREQ consumers and streams the words through a 1-deep valid/ready stage.
module fifo_rd_burst_arb #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int IDW      = 2
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic                         en,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*(ADDRSIZE+1)-1:0] req_len,
    input  logic [NREQ-1:0]              ready,
    input  logic                         rempty,
    input  logic [ADDRSIZE:0]            rq2_wptr,
    input  logic [ADDRSIZE:0]            rptr,
    input  logic [DSIZE-1:0]             rdata,
    output logic                         rinc,
    output logic [NREQ-1:0]              gnt,
    output logic                         out_valid,
    output logic [DSIZE-1:0]             out_data,
    output logic [IDW-1:0]               out_id,
    output logic                         out_last,
    output logic [ADDRSIZE:0]            rlevel
);

    localparam int LW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] ONE   = {{ADDRSIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state, next_state;
    logic [ADDRSIZE:0] wbin, rbin, lvl, remain;
    logic [ADDRSIZE:0] lens [NREQ];
    logic [NREQ-1:0]   elig;
    logic [IDW-1:0]    last, cand, pick;
    logic              found, accept, do_grant, do_release;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        for (int i = 0; i <= ADDRSIZE; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Modulo arithmetic keeps the level correct across pointer wrap; full reads as DEPTH.
    assign wbin = gray2bin(rq2_wptr);
    assign rbin = gray2bin(rptr);
    assign lvl  = wbin - rbin;

    for (genvar i = 0; i < NREQ; i++) begin : g_elig
        assign lens[i] = req_len[i*LW +: LW];
        assign elig[i] = req[i] && (lens[i] != '0) && (lens[i] <= DEPTH) && (lens[i] <= lvl);
    end

    // Scan upward from the consumer after the last one granted.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = last;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDW'(NREQ-1)) ? '0 : cand + 1'b1;
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign accept = out_valid & ready[out_id];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        rinc       = 1'b0;
        do_grant   = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    do_grant   = 1'b1;
                    next_state = BURST;
                end
            end
            BURST: begin
                rinc = (remain != '0) & ~rempty & (~out_valid | ready[out_id]);
                if (rinc && remain == ONE) next_state = DRAIN;
            end
            DRAIN: begin
                if (accept) begin
                    do_release = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A pop refills the output stage; an accept with no pop empties it.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            rlevel    <= '0;
            remain    <= '0;
            last      <= IDW'(NREQ-1);
        end else begin
            rlevel <= lvl;
            if (do_grant) begin
                gnt    <= NREQ'(1) << pick;
                out_id <= pick;
                remain <= lens[pick];
                last   <= pick;
            end
            if (rinc) begin
                out_data  <= rdata;
                out_valid <= 1'b1;
                out_last  <= (remain == ONE);
                remain    <= remain - 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (do_release) gnt <= '0;
        end
    end

endmodule

// File: doc/fifo_rd_burst_arb.md
Name: fifo_rd_burst_arb

Overview:
- Read-domain burst scheduler for the async FIFO. It shares the single FIFO read port among NREQ consumers.
- It computes the FIFO fill level from the synchronized write pointer and the Gray read pointer.
- It grants one consumer at a time, round-robin, and only when the whole requested burst is already present.
- It drives the read-pointer block's rinc and delivers the words through a 1-deep registered valid/ready output stage.

Parameters:
- ADDRSIZE, 4: FIFO address width; depth is 2^ADDRSIZE.
- DSIZE, 8: data word width.
- NREQ, 4: number of consumers; must be at least 2 and no more than 2^IDW.
- IDW, 2: width of out_id.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset.
- en  in  1  grant enable; low blocks new grants, and a burst in progress still completes.
- req  in  NREQ  per-consumer burst request, level-sensitive.
- req_len  in  NREQ*(ADDRSIZE+1)  burst length for consumer i in bits [i*(ADDRSIZE+1) +: ADDRSIZE+1].
- ready  in  NREQ  per-consumer accept.
- rempty  in  1  empty flag from the read-pointer block.
- rq2_wptr  in  ADDRSIZE+1  write pointer in Gray code, synchronized to rclk.
- rptr  in  ADDRSIZE+1  read pointer in Gray code.
- rdata  in  DSIZE  FIFO head word; combinational memory read at the current raddr.
- rinc  out  1  read increment to the read-pointer block.
- gnt  out  NREQ  one-hot grant.
- out_valid  out  1  output word valid.
- out_data  out  DSIZE  output word.
- out_id  out  IDW  index of the granted consumer.
- out_last  out  1  marks the final beat of the burst.
- rlevel  out  ADDRSIZE+1  registered fill level.

Behaviour:
- Reset: rrst_n is asynchronous and active-low; clock is rclk. While reset is asserted:
  - state is IDLE.
  - gnt, out_valid, out_data, out_id, out_last, rlevel and the remaining-beat counter are all 0.
  - The round-robin pointer is NREQ-1, so consumer 0 has first priority.
  - rinc is 0.
- Fill level:
  - Convert both pointers from Gray to binary.
  - lvl = wbin - rbin, taken modulo 2^(ADDRSIZE+1), range 0..2^ADDRSIZE.
  - rlevel is lvl registered every cycle.
  - The grant decision uses the combinational lvl.
- Eligibility: consumer i is eligible when all of the following hold:
  - req[i] is 1.
  - 1 <= len_i <= 2^ADDRSIZE. A request with len 0 or len above 2^ADDRSIZE is never granted and is skipped by the arbiter.
  - len_i <= lvl.
- State IDLE:
  - If en=1 and at least one consumer is eligible, pick the first eligible index scanning upward from (last+1) mod NREQ.
  - At the next edge: gnt becomes one-hot for that consumer, out_id = index, remain = len_i, last = index, state goes to BURST.
  - Grant latency is 1 cycle from eligibility.
- State BURST:
  - rinc = (remain != 0) & ~rempty & (~out_valid | ready[out_id]). It is combinational.
  - On rinc at an edge:
    - out_data <= rdata.
    - out_valid <= 1.
    - remain decrements.
    - out_last <= (remain == 1).
  - Beat latency: the word appears on out_data 1 cycle after rinc.
  - An accept without a new rinc clears out_valid and out_last. An accept and rinc in the same cycle sustain 1 beat per cycle.
  - When the rinc with remain==1 occurs, state goes to DRAIN.
- State DRAIN:
  - Hold gnt and out_id.
  - When out_valid & ready[out_id]: clear out_valid, out_last and gnt; state goes to IDLE.
  - That same edge may not issue a new grant. The minimum gap between bursts is 1 IDLE cycle, so the arbiter always sees the updated rptr.
- Output rules:
  - out_valid, once high, holds out_data and out_last stable until accepted.
  - ready of any consumer other than out_id is ignored.
- Mid-burst input changes: deassertion of req or en, or a change of req_len, during BURST or DRAIN has no effect. The burst always completes with the length latched at grant.
- Empty during BURST: this cannot occur, because lvl >= len at grant and only this block pops. rinc is still gated by ~rempty as a safety measure.
- Wrap-around: the pointer and level arithmetic is modulo 2^(ADDRSIZE+1). It is correct across pointer wrap, and a full FIFO gives lvl = 2^ADDRSIZE.
- Reset mid-burst: the asynchronous reset aborts the burst immediately. Outputs return to their reset values and rinc drops. The read-pointer block shares rrst_n.

Test Plan:
- Single burst: write 5 words (0x11..0x15); req[0]=1, len0=3 -> gnt=0001 one cycle after lvl>=3; out_data 0x11,0x12,0x13 with ready held 1 gives 3 consecutive beats; out_last on 0x13; rlevel settles to 2.
- Round-robin: req=1111, all lens 1, FIFO holds 8 words -> grants in order 0,1,2,3,0,1,2,3; each grant followed by 1 IDLE gap cycle.
- Insufficient data: req[2]=1, len2=6, lvl=4 -> no grant and rinc=0; write 2 more words -> grant within 1 cycle of lvl reaching 6 (after synchronizer delay); 6 beats delivered.
- Backpressure: len=4, ready toggles 1,0,0,1,... -> rinc only when the output stage is free; data order 0xA0..0xA3 preserved; no duplicated or lost words; gnt held through DRAIN until the last beat is accepted.
- Boundary and invalid length: fill FIFO to 16 (ADDRSIZE=4), len1=16 -> granted, FIFO empties, rempty=1 at end; len0=0 and len2=17 never granted while req1 is still served; pointer wrap checked over 40 bursts.
- Reset mid-burst and en: assert rrst_n=0 on the second beat -> all outputs 0 at once, including rinc. Deassert en during a burst -> burst completes and no further grant occurs until en=1.
